// File: rtl/rvfi_monitor_if.sv
// RVFI retirement trace bundle (NRET=1, ILEN=XLEN=32) between the core and the monitor.
interface rvfi_monitor_if;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic [1:0]  rvfi_ixl;
  logic [4:0]  rvfi_rs1_addr;
  logic [4:0]  rvfi_rs2_addr;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata;
  logic [31:0] rvfi_rs2_rdata;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_ixl,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
           rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
           rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask
  );

  modport slave (
    input rvfi_valid, rvfi_order, rvfi_insn, rvfi_ixl,
          rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
          rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
          rvfi_pc_rdata, rvfi_pc_wdata,
          rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask
  );
endinterface

// File: rtl/rvfi_monitor.sv
// RVFI retirement checker: shadow regfile, expected PC/order, first-error capture.
// Optional memory-mask check enabled by defining RVFI_MONITOR_MEM_CHECK_EN.
module rvfi_monitor #(
  parameter bit STOP_ON_ERROR = 1'b1,
  parameter bit CHECK_X0      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rvfi_monitor_if.slave        rvfi,
  output logic                 err,
  output logic [7:0]           err_code,
  output logic [63:0]          err_order,
  output logic [31:0]          err_pc,
  output logic [31:0]          check_count
);

  typedef enum logic [1:0] {SEED, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [63:0] exp_order;
  logic [31:0] exp_pc;
  logic [31:0] shadow [32];
  logic [31:0] shadow_vld;
  logic [7:0]  chk;
  logic        mem_bad;
  logic        live;
  logic        upd;

`ifdef RVFI_MONITOR_MEM_CHECK_EN
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  function automatic logic mask_legal(input logic [3:0] m);
    return m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  logic [3:0] mask;
  logic [1:0] ofs;
  logic [6:0] op;

  always_comb begin
    mask    = rvfi.rvfi_mem_rmask | rvfi.rvfi_mem_wmask;
    ofs     = rvfi.rvfi_mem_addr[1:0];
    op      = rvfi.rvfi_insn[6:0];
    mem_bad = 1'b0;
    if (rvfi.rvfi_mem_rmask != '0 && rvfi.rvfi_mem_wmask != '0) mem_bad = 1'b1;
    if (rvfi.rvfi_mem_rmask != '0 && !mask_legal(rvfi.rvfi_mem_rmask)) mem_bad = 1'b1;
    if (rvfi.rvfi_mem_wmask != '0 && !mask_legal(rvfi.rvfi_mem_wmask)) mem_bad = 1'b1;
    // Off-word offsets allow only a single byte at that lane or the upper halfword.
    if (ofs != 2'd0 && mask != '0 &&
        !(mask == (4'b0001 << ofs) || (ofs == 2'd2 && mask == 4'b1100))) mem_bad = 1'b1;
    if (rvfi.rvfi_mem_wmask != '0 && op != OP_STORE) mem_bad = 1'b1;
    if (rvfi.rvfi_mem_rmask != '0 && op != OP_LOAD)  mem_bad = 1'b1;
    if (op == OP_STORE && rvfi.rvfi_mem_wmask == '0) mem_bad = 1'b1;
  end
`else
  logic unused_mem;
  assign unused_mem = ^{rvfi.rvfi_mem_addr, rvfi.rvfi_mem_rmask,
                        rvfi.rvfi_mem_wmask, rvfi.rvfi_insn};
  assign mem_bad = 1'b0;
`endif

  always_comb begin
    chk    = '0;
    chk[2] = (rvfi.rvfi_rs1_addr == '0) ? (rvfi.rvfi_rs1_rdata != '0)
           : (shadow_vld[rvfi.rvfi_rs1_addr] && rvfi.rvfi_rs1_rdata != shadow[rvfi.rvfi_rs1_addr]);
    chk[3] = (rvfi.rvfi_rs2_addr == '0) ? (rvfi.rvfi_rs2_rdata != '0)
           : (shadow_vld[rvfi.rvfi_rs2_addr] && rvfi.rvfi_rs2_rdata != shadow[rvfi.rvfi_rs2_addr]);
    chk[4] = CHECK_X0 && rvfi.rvfi_rd_addr == '0 && rvfi.rvfi_rd_wdata != '0;
    chk[5] = mem_bad;
    chk[7] = rvfi.rvfi_ixl != 2'd1;
    if (state_q == RUN) begin
      chk[0] = rvfi.rvfi_order != exp_order;
      chk[1] = rvfi.rvfi_pc_rdata != exp_pc;
      chk[6] = rvfi.rvfi_pc_wdata[1:0] != 2'd0;
    end
  end

  always_comb begin
    live    = rvfi.rvfi_valid && state_q != HALT;
    upd     = live && !(STOP_ON_ERROR && chk != '0);
    state_d = state_q;
    if (live) begin
      if (STOP_ON_ERROR && chk != '0) state_d = HALT;
      else if (state_q == SEED)       state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEED;
      err         <= 1'b0;
      err_code    <= '0;
      err_order   <= '0;
      err_pc      <= '0;
      check_count <= '0;
      exp_order   <= '0;
      exp_pc      <= '0;
      shadow_vld  <= '0;
    end else begin
      state_q <= state_d;
      if (live && chk != '0 && !err) begin
        err       <= 1'b1;
        err_code  <= chk;
        err_order <= rvfi.rvfi_order;
        err_pc    <= rvfi.rvfi_pc_rdata;
      end
      if (upd) begin
        exp_order <= rvfi.rvfi_order + 64'd1;
        exp_pc    <= rvfi.rvfi_pc_wdata;
        if (rvfi.rvfi_rd_addr != '0) shadow_vld[rvfi.rvfi_rd_addr] <= 1'b1;
        if (check_count != '1) check_count <= check_count + 32'd1;
      end
    end
  end

  // Data array needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (rst_n && upd && rvfi.rvfi_rd_addr != '0)
      shadow[rvfi.rvfi_rd_addr] <= rvfi.rvfi_rd_wdata;
  end

endmodule

// File: tb/tb_rvfi_monitor.sv
// Scoreboard bench for rvfi_monitor: DUT A (stop-on-error, x0 check) and DUT B (free-running, no x0 check).
module tb_rvfi_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rvfi_monitor_if bus ();

  logic        err_a, err_b;
  logic [7:0]  code_a, code_b;
  logic [63:0] ord_a, ord_b;
  logic [31:0] pc_a, pc_b, cnt_a, cnt_b;

  rvfi_monitor #(.STOP_ON_ERROR(1'b1), .CHECK_X0(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rvfi(bus.slave),
    .err(err_a), .err_code(code_a), .err_order(ord_a), .err_pc(pc_a), .check_count(cnt_a));

  rvfi_monitor #(.STOP_ON_ERROR(1'b0), .CHECK_X0(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rvfi(bus.slave),
    .err(err_b), .err_code(code_b), .err_order(ord_b), .err_pc(pc_b), .check_count(cnt_b));

  typedef struct {
    logic [63:0] order;
    logic [31:0] pc, npc, insn, rs1d, rs2d, rdw, addr;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  rm, wm;
    logic [1:0]  ixl;
  } pkt_t;

  typedef struct {
    logic        ea;
    logic [7:0]  ca;
    logic [63:0] oa;
    logic [31:0] pa, na;
    logic        eb;
    logic [7:0]  cb;
    logic [31:0] nb;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic acc = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk(input logic [63:0] o, input logic [31:0] pc);
    pkt_t p;
    p.order = o;    p.pc = pc;     p.npc = pc + 32'd4; p.insn = 32'h0000_0013;
    p.rs1 = '0;     p.rs2 = '0;    p.rd = '0;
    p.rs1d = '0;    p.rs2d = '0;   p.rdw = '0;
    p.addr = '0;    p.rm = '0;     p.wm = '0;          p.ixl = 2'd1;
    return p;
  endfunction

  function automatic exp_t ex(input logic ea, input logic [7:0] ca, input logic [63:0] oa,
                              input logic [31:0] pa, input logic [31:0] na,
                              input logic eb, input logic [7:0] cb, input logic [31:0] nb);
    exp_t e;
    e.ea = ea; e.ca = ca; e.oa = oa; e.pa = pa; e.na = na;
    e.eb = eb; e.cb = cb; e.nb = nb;
    return e;
  endfunction

  task automatic drive(input pkt_t p, input logic v);
    bus.rvfi_valid     = v;
    bus.rvfi_order     = p.order;
    bus.rvfi_insn      = p.insn;
    bus.rvfi_ixl       = p.ixl;
    bus.rvfi_rs1_addr  = p.rs1;
    bus.rvfi_rs2_addr  = p.rs2;
    bus.rvfi_rd_addr   = p.rd;
    bus.rvfi_rs1_rdata = p.rs1d;
    bus.rvfi_rs2_rdata = p.rs2d;
    bus.rvfi_rd_wdata  = p.rdw;
    bus.rvfi_pc_rdata  = p.pc;
    bus.rvfi_pc_wdata  = p.npc;
    bus.rvfi_mem_addr  = p.addr;
    bus.rvfi_mem_rmask = p.rm;
    bus.rvfi_mem_wmask = p.wm;
  endtask

  task automatic send(input pkt_t p, input exp_t e);
    @(negedge clk);
    drive(p, 1'b1);
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.rvfi_valid = 1'b0;
  endtask

  // Optional valid packet held during the reset cycle must be discarded.
  task automatic do_reset(input logic v, input pkt_t p);
    @(negedge clk);
    drive(p, v);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rvfi_valid = 1'b0;
    chk("rst_err_a",  err_a,  0);
    chk("rst_code_a", code_a, 0);
    chk("rst_ord_a",  ord_a,  0);
    chk("rst_pc_a",   pc_a,   0);
    chk("rst_cnt_a",  cnt_a,  0);
    chk("rst_err_b",  err_b,  0);
    chk("rst_cnt_b",  cnt_b,  0);
  endtask

  always @(posedge clk) acc <= bus.rvfi_valid && rst_n;

  always @(negedge clk) begin
    if (acc) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("err_a",   err_a,  e.ea);
        chk("code_a",  code_a, e.ca);
        chk("order_a", ord_a,  e.oa);
        chk("pc_a",    pc_a,   e.pa);
        chk("count_a", cnt_a,  e.na);
        chk("err_b",   err_b,  e.eb);
        chk("code_b",  code_b, e.cb);
        chk("count_b", cnt_b,  e.nb);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p;
    drive(mk(0, 0), 1'b0);

    // Clean stream of ten packets
    do_reset(1'b0, mk(0, 0));
    for (int i = 0; i < 10; i++)
      send(mk(64'd100 + 64'(i), 32'(i * 4)), ex(0, 0, 0, 0, 32'(i + 1), 0, 0, 32'(i + 1)));
    idle();

    // Order skip on the fourth packet
    do_reset(1'b0, mk(0, 0));
    send(mk(100, 32'h0), ex(0, 0, 0, 0, 1, 0, 0, 1));
    send(mk(101, 32'h4), ex(0, 0, 0, 0, 2, 0, 0, 2));
    send(mk(102, 32'h8), ex(0, 0, 0, 0, 3, 0, 0, 3));
    send(mk(105, 32'hC), ex(1, 8'h01, 105, 32'hC, 3, 1, 8'h01, 4));
    send(mk(106, 32'h10), ex(1, 8'h01, 105, 32'hC, 3, 1, 8'h01, 5));
    idle();

    // Shadow register file read-after-write and same-register read/write
    do_reset(1'b0, mk(0, 0));
    p = mk(0, 32'h0); p.rd = 5; p.rdw = 32'hDEADBEEF;
    send(p, ex(0, 0, 0, 0, 1, 0, 0, 1));
    p = mk(1, 32'h4); p.rs1 = 5; p.rs1d = 32'hDEADBEEF; p.rs2 = 7; p.rs2d = 32'h1234;
    send(p, ex(0, 0, 0, 0, 2, 0, 0, 2));
    p = mk(2, 32'h8); p.rs1 = 5; p.rs1d = 32'hDEADBEEF; p.rd = 5; p.rdw = 32'h1111_1111;
    send(p, ex(0, 0, 0, 0, 3, 0, 0, 3));
    p = mk(3, 32'hC); p.rs1 = 5; p.rs1d = 32'h1111_1111;
    send(p, ex(0, 0, 0, 0, 4, 0, 0, 4));
    p = mk(4, 32'h10); p.rs1 = 5; p.rs1d = 32'hDEADBEEE;
    send(p, ex(1, 8'h04, 4, 32'h10, 4, 1, 8'h04, 5));
    idle();

    // x0 written non-zero on the seed packet
    do_reset(1'b0, mk(0, 0));
    p = mk(0, 32'h0); p.rdw = 32'h1;
    send(p, ex(1, 8'h10, 0, 0, 0, 0, 0, 1));
    send(mk(1, 32'h4), ex(1, 8'h10, 0, 0, 0, 0, 0, 2));
    idle();

    // Memory masks: legal load, then misaligned store halfword
    do_reset(1'b0, mk(0, 0));
    p = mk(0, 32'h0); p.insn = 32'h0000_2003; p.rm = 4'b1111; p.addr = 32'h1000;
    send(p, ex(0, 0, 0, 0, 1, 0, 0, 1));
    p = mk(1, 32'h4); p.insn = 32'h0000_2023; p.wm = 4'b0110; p.addr = 32'h1001;
`ifdef RVFI_MONITOR_MEM_CHECK_EN
    send(p, ex(1, 8'h20, 1, 32'h4, 1, 1, 8'h20, 2));
`else
    send(p, ex(0, 0, 0, 0, 2, 0, 0, 2));
`endif
    idle();

    // Misaligned next PC together with wrong XLEN code
    do_reset(1'b0, mk(0, 0));
    send(mk(0, 32'h0), ex(0, 0, 0, 0, 1, 0, 0, 1));
    p = mk(1, 32'h4); p.npc = 32'hA; p.ixl = 2'd2;
    send(p, ex(1, 8'hC0, 1, 32'h4, 1, 1, 8'hC0, 2));
    idle();

    // Reset mid-stream with a valid packet on the reset edge
    do_reset(1'b0, mk(0, 0));
    send(mk(7, 32'h100), ex(0, 0, 0, 0, 1, 0, 0, 1));
    send(mk(8, 32'h104), ex(0, 0, 0, 0, 2, 0, 0, 2));
    send(mk(9, 32'h108), ex(0, 0, 0, 0, 3, 0, 0, 3));
    do_reset(1'b1, mk(10, 32'h10C));
    send(mk(0, 32'h500), ex(0, 0, 0, 0, 1, 0, 0, 1));
    send(mk(1, 32'h504), ex(0, 0, 0, 0, 2, 0, 0, 2));
    idle();

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rvfi_monitor.md
Name: rvfi_monitor

Overview:
- Consumer end of the RVFI retirement trace (NRET=1, ILEN=XLEN=32) emitted by the RISC-V datapath.
- Keeps a 32-entry shadow register file, the expected PC and the expected order number, and checks every retired packet against them.
- Latches the first failure for debug and counts checked packets.
- Simulation and FPGA bring-up block; sits beside the core and never drives it.

Parameters:
- STOP_ON_ERROR, 1, 1 = after the first error, freeze all state and stop checking; 0 = keep checking, the capture registers still hold the first error.
- CHECK_X0, 1, 1 = enable check bit 4 (x0 rule); 0 = bit 4 is forced to 0.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- rvfi_valid  in  1  packet valid
- rvfi_order  in  64  retirement index
- rvfi_insn  in  32  instruction word
- rvfi_ixl  in  2  XLEN code
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  in  5 each  register indices
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  in  32 each  register data
- rvfi_pc_rdata, rvfi_pc_wdata  in  32 each  PC before/after
- rvfi_mem_addr  in  32  memory address
- rvfi_mem_rmask, rvfi_mem_wmask  in  4 each  byte masks
- err  out  1  sticky: an error has been seen
- err_code  out  8  check bits of the first failing packet
- err_order  out  64  rvfi_order of the first failing packet
- err_pc  out  32  rvfi_pc_rdata of the first failing packet
- check_count  out  32  packets checked, saturating at 0xFFFFFFFF

Behaviour:
- One clock domain, clocked on posedge clk. Reset is synchronous, active-low on rst_n.
- Reset values: err=0, err_code=0, err_order=0, err_pc=0, check_count=0. Internal state also clears: seeded=0, all shadow valid bits=0. Reset mid-stream discards the packet on that edge.
- A packet is accepted on any clk edge with rvfi_valid=1 and rst_n=1. There is no backpressure; the monitor accepts one packet per cycle.
- State machine SEED -> RUN -> HALT.
  - SEED: the first accepted packet after reset runs no order or PC check; it only seeds the expected values, then the FSM moves to RUN.
  - RUN: every accepted packet is checked.
  - HALT: entered only when STOP_ON_ERROR=1 and an error is latched; only rst_n exits it.
- Check bits, computed combinationally on the accepted packet and all checked in RUN; SEED runs bits 2-5 and 7:
  - 0 ORDER: rvfi_order != exp_order.
  - 1 PC: rvfi_pc_rdata != exp_pc.
  - 2 RS1: rs1_addr!=0, shadow entry valid, and rs1_rdata != shadow[rs1_addr]; or rs1_addr==0 and rs1_rdata!=0.
  - 3 RS2: same rule applied to rs2.
  - 4 X0: rd_addr==0 and rd_wdata!=0.
  - 5 MEM: see Optional Feature.
  - 6 ALIGN: pc_wdata[1:0]!=0.
  - 7 IXL: ixl!=2'd1.
- Update on every accepted packet, unless in HALT:
  - exp_order = order+1, wrapping modulo 2^64.
  - exp_pc = pc_wdata.
  - if rd_addr!=0: shadow[rd_addr]=rd_wdata and its valid bit is set.
  - check_count increments.
- Read/write timing: shadow is read before it is written. A packet reading a register written by the previous packet sees the updated value, because the previous edge has already written it. A packet whose rs and rd are the same register checks against the old value.
- Error capture:
  - On the first packet with any bit set, register err_code/err_order/err_pc and set err=1. All are visible the cycle after the failing edge.
  - Later errors never overwrite the capture registers.
- Registers with no valid bit set are not checked: reads before the first write are not checked.

Optional Feature:
- Macro RVFI_MONITOR_MEM_CHECK_EN.
- Defined: bit 5 fires on any of:
  - rmask!=0 and wmask!=0 together.
  - A nonzero mask that is not 0001/0010/0100/1000/0011/1100/1111.
  - A mask shifted by a nonzero mem_addr[1:0] that is not naturally aligned.
  - wmask!=0 while insn[6:0]!=7'b0100011.
  - rmask!=0 while insn[6:0]!=7'b0000011.
  - insn[6:0]==7'b0100011 with wmask==0.
- Undefined: bit 5 is forced to 0 and the memory ports are ignored.

Test Plan:
- Reset, then 10 packets with order 100..109, pc_rdata 0x0..0x24 step 4 and pc_wdata=pc_rdata+4 -> err=0, check_count=10.
- Packet 3 has order 105 instead of 103 -> err=1, err_code=8'h01, err_order=105 the next cycle; with STOP_ON_ERROR=1, check_count stays 3.
- Write x5=0xDEADBEEF, then the next packet reads rs1=x5 with rdata 0xDEADBEEE -> err_code=8'h04. A read of x7 that has never been written passes.
- Packet rd_addr=0, rd_wdata=1 -> err_code=8'h10; with CHECK_X0=0 -> err=0.
- With MEM_CHECK_EN defined: sw with wmask=4'b0110 at addr[1:0]=1 -> err_code=8'h20. Undefined: err=0.
- rst_n low for one cycle mid-stream, then order restarts at 0 with an arbitrary pc -> no error, check_count counts from 0.
